morse_decoder: RTL and testbench
================================

// Module: morse_decoder
// PURPOSE
//  Receive side of the Morse link: samples a single key/lamp line and times marks and spaces
//  with a restartable half-second tick. Classifies each mark as dot or dash, ends a letter
//  after a long space, and decodes letters A-H to the same 3-bit code the transmitter's SW[2:0] uses.
//  Sits between a KEY/GPIO input (or the transmitter's led_on in loopback) and LEDR/HEX display logic.
// PARAMETERS
//  TICK_CYCLES     25_000_000  clk cycles per tick (0.5 s at 50 MHz); >=2; sims use 4
//  DASH_MIN_TICKS  2           mark of >= this many whole ticks is a dash, else a dot
//  GAP_MIN_TICKS   2           space of this many whole ticks ends the letter
// PORTS
//  clk           in   1  system clock (CLOCK_50)
//  resetn        in   1  reset, asynchronous, active-low
//  key_in        in   1  raw mark level, 1 = lamp on / key down; asynchronous to clk
//  letter        out  3  last decoded letter: 0=A .. 7=H; holds until next valid letter
//  letter_valid  out  1  one-cycle pulse: letter just updated
//  err           out  1  one-cycle pulse: letter ended with no table match or >4 symbols
//  busy          out  1  high whenever state != IDLE
// BEHAVIOUR
//  - One clock (clk). Reset asynchronous, active-low (resetn); all flops clear, all outputs 0, state IDLE.
//  - key_in passes through a 2-flop synchronizer (2-cycle latency) to key_s; all logic uses key_s.
//  - Tick timer: cycle counter restarts to 0 on each key_s edge and on EMIT exit. Pulses tick when
//    count == TICK_CYCLES-1, then wraps. A saturating 2-bit tick_cnt counts ticks in the interval.
//  - Symbol store: 4-bit MSB-first left-aligned pattern (dash=1, dot=0) plus 3-bit sym_len. Same
//    encoding as the transmitter: A=0100/2, B=1000/4, C=1010/4, D=1000/3, E=0000/1, F=0010/4, G=1100/3, H=0000/4.
//  - FSM states: IDLE, MARK, SPACE, EMIT.
//    IDLE : pattern, sym_len, ovf cleared. key_s=1 -> MARK (timer restarted).
//    MARK : key_s=0 -> SPACE. Append dash if tick_cnt>=DASH_MIN_TICKS, else dot, at bit 3-sym_len.
//           sym_len++. If sym_len was already 4, set ovf and drop the symbol (sym_len stays 4).
//           A long mark saturates and stays a dash; no timeout.
//    SPACE: key_s=1 before GAP_MIN_TICKS ticks -> MARK, same letter.
//           tick_cnt reaching GAP_MIN_TICKS -> EMIT.
//    EMIT : one cycle. Look up {pattern,sym_len}. On match and !ovf: letter<=code, letter_valid=1.
//           Otherwise err=1 and letter holds its value.
//           Next state is MARK if key_s=1 (new letter, timer restarted), else IDLE.
//  - letter_valid/err are registered, high only in the cycle after entering EMIT; never both high.
//  - Latency: pulse appears GAP_MIN_TICKS*TICK_CYCLES + 1 cycles after the falling edge of key_s.
//  - Reset mid-letter discards the partial letter with no pulse. Glitches <1 clk on key_in are not filtered.
// CONFIGURATION
//  MORSE_DEC_RAW_EN defined:
//    - adds outputs raw_pattern[3:0] and raw_len[2:0], registered copies of the store at EMIT.
//    - they update on every EMIT (match or err) and reset to 0.
//  Undefined: these ports and flops do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package morse_pkg holds:
//    state encoding (IDLE/MARK/SPACE/EMIT); letter codes A..H;
//    the pattern/length table as localparam arrays (shared with the transmitter mux1/mux2);
//    the MAX_SYMS=4 constant.
//  - Sub-module morse_tick_timer (TICK_CYCLES param; ports clk, resetn, restart -> tick):
//    the restartable tick counter.
//  - FSM, symbol store and lookup stay in morse_decoder.
// TESTING (TICK_CYCLES=4, DASH/GAP_MIN_TICKS=2)
//  1 'A': key 4 cyc high, 4 low, 12 high, then low:
//    -> letter=3'd0 and letter_valid pulse 1 cycle, 9+2 cycles after final release; err=0.
//  2 'E' (one 4-cyc mark), then 'H' (four 4-cyc marks, 4-cyc spaces):
//    -> letter 3'd4, then 3'd7; B vs D and E vs H distinguished by length.
//  3 Single 12-cyc dash (no match):
//    -> err pulse, letter_valid=0, letter keeps previous value.
//    Five dots -> err pulse (overflow).
//  4 Loopback from the transmitter (same TICK) for SW=0..7:
//    -> letter equals SW each time; no err pulses.
//  5 resetn low mid-MARK of 'C' -> outputs 0 immediately, no pulse.
//    Then key pressed in the EMIT cycle -> next letter decoded correctly.
//  6 Key held 100 cycles -> dash, busy=1 throughout.
//    With MORSE_DEC_RAW_EN: raw_pattern=4'b1000, raw_len=3'd1.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, letter codes A-H and the dot/dash pattern table
// that the transmitter muxes also use.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        EMIT  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        LETTER_A = 3'd0,
        LETTER_B = 3'd1,
        LETTER_C = 3'd2,
        LETTER_D = 3'd3,
        LETTER_E = 3'd4,
        LETTER_F = 3'd5,
        LETTER_G = 3'd6,
        LETTER_H = 3'd7
    } letter_e;

    localparam int MAX_SYMS    = 4;
    localparam int NUM_LETTERS = 8;

    // MSB-first, left-aligned, dash=1; unused low bits are always 0.
    localparam logic [3:0] PATTERN_TABLE [0:NUM_LETTERS-1] = '{
        4'b0100, 4'b1000, 4'b1010, 4'b1000, 4'b0000, 4'b0010, 4'b1100, 4'b0000
    };
    localparam logic [2:0] LEN_TABLE [0:NUM_LETTERS-1] = '{
        3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4
    };

    typedef struct packed {
        logic    hit;
        letter_e code;
    } lookup_t;

    function automatic lookup_t lookup_letter(input logic [3:0] pattern, input logic [2:0] len);
        lookup_t r;
        r.hit  = 1'b0;
        r.code = LETTER_A;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (PATTERN_TABLE[i] == pattern && LEN_TABLE[i] == len) begin
                r.hit  = 1'b1;
                r.code = letter_e'(3'(i));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_tick_timer.sv
// Restartable tick generator: tick is high for one cycle every TICK_CYCLES cycles,
// counted from the last restart.
module morse_tick_timer #(
    parameter int TICK_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count;

    // NOTE: every flop here and below is written with <= only, so all registers
    // see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: times marks/spaces on a synchronized key line and decodes letters A-H.
// Define MORSE_DEC_RAW_EN to add raw_pattern/raw_len debug outputs captured at each letter end.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int TICK_CYCLES    = 25_000_000,
    parameter int DASH_MIN_TICKS = 2,
    parameter int GAP_MIN_TICKS  = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       err,
    output logic       busy
`ifdef MORSE_DEC_RAW_EN
    ,
    output logic [3:0] raw_pattern,
    output logic [2:0] raw_len
`endif
);

    localparam logic [1:0] DASH_TICKS = 2'(DASH_MIN_TICKS);
    localparam logic [1:0] GAP_TICKS  = 2'(GAP_MIN_TICKS);

    logic       key_meta, key_s, key_q;
    logic       restart, tick;
    logic [1:0] tick_cnt, ticks_now;
    state_e     state;
    logic [3:0] pattern;
    logic [2:0] sym_len;
    logic       ovf;
    lookup_t    found;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_meta <= 1'b0;
            key_s    <= 1'b0;
            key_q    <= 1'b0;
        end else begin
            key_meta <= key_in;
            key_s    <= key_meta;
            key_q    <= key_s;
        end
    end

    assign restart = (key_s ^ key_q) || (state == EMIT);

    morse_tick_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .restart (restart),
        .tick    (tick)
    );

    // Whole ticks elapsed including one completing this cycle, so a level change
    // exactly on a tick boundary still counts that tick.
    always_comb begin
        ticks_now = tick_cnt;
        if (tick && tick_cnt != 2'd3) begin
            ticks_now = tick_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= 2'd0;
        end else if (restart) begin
            tick_cnt <= 2'd0;
        end else begin
            tick_cnt <= ticks_now;
        end
    end

    assign found = lookup_letter(pattern, sym_len);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            pattern      <= 4'd0;
            sym_len      <= 3'd0;
            ovf          <= 1'b0;
            letter       <= 3'd0;
            letter_valid <= 1'b0;
            err          <= 1'b0;
`ifdef MORSE_DEC_RAW_EN
            raw_pattern  <= 4'd0;
            raw_len      <= 3'd0;
`endif
        end else begin
            letter_valid <= 1'b0;
            err          <= 1'b0;
            case (state)
                IDLE: begin
                    pattern <= 4'd0;
                    sym_len <= 3'd0;
                    ovf     <= 1'b0;
                    if (key_s) state <= MARK;
                end
                MARK: begin
                    if (!key_s) begin
                        state <= SPACE;
                        if (sym_len == 3'(MAX_SYMS)) begin
                            ovf <= 1'b1;
                        end else begin
                            pattern[2'd3 - sym_len[1:0]] <= (ticks_now >= DASH_TICKS);
                            sym_len                      <= sym_len + 3'd1;
                        end
                    end
                end
                SPACE: begin
                    // Outputs are registered on entry so the pulse is visible during EMIT.
                    if (ticks_now >= GAP_TICKS) begin
                        state <= EMIT;
                        if (found.hit && !ovf) begin
                            letter       <= found.code;
                            letter_valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
`ifdef MORSE_DEC_RAW_EN
                        raw_pattern <= pattern;
                        raw_len     <= sym_len;
`endif
                    end else if (key_s) begin
                        state <= MARK;
                    end
                end
                EMIT: begin
                    pattern <= 4'd0;
                    sym_len <= 3'd0;
                    ovf     <= 1'b0;
                    state   <= key_s ? MARK : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: directed letters plus randomized keying against
// a string-level Morse reference model with pulse timing derived from the tick rules.
module tb_morse_decoder;

    localparam int TICK   = 4;
    localparam int DASH_T = 2;
    localparam int GAP_T  = 2;
    localparam int LAT    = 2 + GAP_T * TICK + 1;

    logic       clk = 1'b0;
    logic       resetn;
    logic       key_in;
    logic [2:0] letter;
    logic       letter_valid;
    logic       err;
    logic       busy;
`ifdef MORSE_DEC_RAW_EN
    logic [3:0] raw_pattern;
    logic [2:0] raw_len;
`endif

    always #5 clk = ~clk;

    morse_decoder #(
        .TICK_CYCLES    (TICK),
        .DASH_MIN_TICKS (DASH_T),
        .GAP_MIN_TICKS  (GAP_T)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .key_in       (key_in),
        .letter       (letter),
        .letter_valid (letter_valid),
        .err          (err),
        .busy         (busy)
`ifdef MORSE_DEC_RAW_EN
        ,
        .raw_pattern  (raw_pattern),
        .raw_len      (raw_len)
`endif
    );

    typedef struct {
        int         cyc;
        bit         is_err;
        logic [2:0] letter;
    } ev_t;

    string      code_table [0:7] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
    ev_t        exp_q[$];
    ev_t        got_q[$];
    logic [2:0] last_valid = 3'd0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && (letter_valid || err)) begin
            ev_t e;
            e.cyc    = cyc;
            e.is_err = err;
            e.letter = letter;
            got_q.push_back(e);
            check("pulse_exclusive", letter_valid & err, 0);
        end
    end

    task automatic hold(input logic level, input int n);
        key_in = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic predict(input string sym, input int when);
        ev_t e;
        e.cyc    = when;
        e.is_err = 1'b1;
        e.letter = last_valid;
        if (sym.len() <= 4) begin
            for (int i = 0; i < 8; i++) begin
                if (sym == code_table[i]) begin
                    e.is_err = 1'b0;
                    e.letter = 3'(i);
                end
            end
        end
        if (!e.is_err) last_valid = e.letter;
        exp_q.push_back(e);
    endtask

    task automatic send_letter(input int marks[$], input int gaps[$], input int end_gap);
        string sym = "";
        string d;
        for (int i = 0; i < marks.size(); i++) begin
            d   = ((marks[i] / TICK) >= DASH_T) ? "-" : ".";
            sym = {sym, d};
            hold(1'b1, marks[i]);
            if (i < marks.size() - 1) hold(1'b0, gaps[i]);
        end
        predict(sym, cyc + LAT);
        hold(1'b0, end_gap);
    endtask

    task automatic send_code(input string code, input int dot, input int dash, input int gap, input int end_gap);
        int marks[$];
        int gaps[$];
        for (int i = 0; i < code.len(); i++) begin
            marks.push_back(code[i] == "-" ? dash : dot);
            gaps.push_back(gap);
        end
        send_letter(marks, gaps, end_gap);
    endtask

    task automatic compare_events(input string phase);
        int n;
        check($sformatf("%s_count", phase), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_%0d_cycle", phase, i), got_q[i].cyc, exp_q[i].cyc);
            check($sformatf("%s_%0d_err", phase, i), got_q[i].is_err, exp_q[i].is_err);
            check($sformatf("%s_%0d_letter", phase, i), got_q[i].letter, exp_q[i].letter);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        key_in = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_letter", letter, 0);
        check("reset_valid", letter_valid, 0);
        check("reset_err", err, 0);
        check("reset_busy", busy, 0);
        resetn = 1'b1;
        hold(1'b0, 4);

        send_code(".-", 4, 12, 4, 16);
        compare_events("letter_a");

        send_code(".", 4, 12, 4, 16);
        send_code("....", 4, 12, 4, 16);
        send_code("-...", 4, 12, 4, 16);
        send_code("-..", 4, 12, 4, 16);
        compare_events("length_split");

        send_code("-", 4, 12, 4, 16);
        send_code(".....", 4, 12, 4, 16);
        compare_events("no_match");

        for (int sw = 0; sw < 8; sw++) begin
            send_code(code_table[sw], 4, 12, 4, 12);
        end
        compare_events("loopback");

        for (int n = 0; n < 40; n++) begin
            int marks[$];
            int gaps[$];
            int nsym;
            bit dash;
            string code;
            if ($urandom_range(0, 3) != 0) begin
                code = code_table[$urandom_range(0, 7)];
                nsym = code.len();
            end else begin
                code = "";
                nsym = $urandom_range(1, 5);
            end
            for (int i = 0; i < nsym; i++) begin
                dash = (code.len() != 0) ? (code[i] == "-") : 1'($urandom_range(0, 1));
                marks.push_back(dash ? $urandom_range(8, 20) : $urandom_range(1, 7));
                gaps.push_back($urandom_range(1, 7));
            end
            send_letter(marks, gaps, $urandom_range(9, 14));
        end
        hold(1'b0, 4);
        compare_events("random");

        send_code("....", 4, 12, 4, 16);
        compare_events("before_reset");
        hold(1'b1, 12);
        hold(1'b0, 4);
        hold(1'b1, 2);
        resetn = 1'b0;
        #1;
        check("midreset_letter", letter, 0);
        check("midreset_valid", letter_valid, 0);
        check("midreset_err", err, 0);
        check("midreset_busy", busy, 0);
        key_in     = 1'b0;
        last_valid = 3'd0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        hold(1'b0, 20);
        compare_events("reset_discard");

        send_code(".", 4, 12, 4, 9);
        send_code(".-", 4, 12, 4, 16);
        compare_events("press_in_emit");

        key_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i >= 3 && i % 16 == 0) check($sformatf("busy_hold_%0d", i), busy, 1);
            @(negedge clk);
        end
        predict("-", cyc + LAT);
        key_in = 1'b0;
        repeat (LAT) @(negedge clk);
`ifdef MORSE_DEC_RAW_EN
        check("raw_pattern", raw_pattern, 4'b1000);
        check("raw_len", raw_len, 3'd1);
`endif
        hold(1'b0, 6);
        compare_events("long_hold");
        check("busy_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
